ngen_loader: RTL and testbench

NGEN_LOADER -- requirements
Module: ngen_loader

---
 rtl/ngen_loader_pkg.sv | 15 +
 rtl/ngen_loader_if.sv | 27 ++
 rtl/ngen_loader_rq_freeze.sv | 27 ++
 rtl/ngen_loader.sv | 89 ++++++++
 tb/tb_ngen_loader.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ngen_loader_pkg.sv
// Shared constants and FSM encoding for the Streamlined NTRU Prime coefficient loaders.
package ngen_loader_pkg;

    localparam int NG_P      = 761;
    localparam int NG_Q      = 4591;
    localparam int NG_ADDR_W = 11;
    localparam int NG_DATA_W = 13;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FINISH = 2'd2
    } ld_state_t;

endpackage

// File: rtl/ngen_loader_if.sv
// Coefficient input stream and RAM write port bundles used by the loader.
interface ngen_coef_if
    import ngen_loader_pkg::*;
#(
    parameter int DATA_W = NG_DATA_W
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_coef;

    modport master (output in_valid, output in_coef, input in_ready);
    modport slave  (input in_valid, input in_coef, output in_ready);
endinterface

interface ngen_wr_if
    import ngen_loader_pkg::*;
#(
    parameter int ADDR_W = NG_ADDR_W,
    parameter int DATA_W = NG_DATA_W
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (output mem_we, output mem_waddr, output mem_wdata);
    modport slave  (input mem_we, input mem_waddr, input mem_wdata);
endinterface

// File: rtl/ngen_loader_rq_freeze.sv
// Maps a centered coefficient into [0,Q) and flags values outside +/-(Q-1)/2.
module rq_freeze
    import ngen_loader_pkg::*;
#(
    parameter int Q      = NG_Q,
    parameter int DATA_W = NG_DATA_W
) (
    input  logic signed [DATA_W-1:0] x,
    output logic        [DATA_W-1:0] y,
    output logic                     bad
);

    localparam logic signed [DATA_W:0] Q_EXT  = (DATA_W+1)'(Q);
    localparam logic signed [DATA_W:0] HALF   = (DATA_W+1)'((Q - 1) / 2);
    localparam logic signed [DATA_W:0] NHALF  = -HALF;

    logic signed [DATA_W:0] x_ext;
    logic signed [DATA_W:0] sum;

    always_comb begin
        x_ext = {x[DATA_W-1], x};
        sum   = x_ext + Q_EXT;
        y     = x[DATA_W-1] ? DATA_W'(sum) : x;
        bad   = (x_ext > HALF) || (x_ext < NHALF);
    end

endmodule

// File: rtl/ngen_loader.sv
// Loads one P-coefficient polynomial from a valid/ready stream into a RAM, frozen to [0,Q).
module ngen_loader
    import ngen_loader_pkg::*;
#(
    parameter int P      = NG_P,
    parameter int Q      = NG_Q,
    parameter int ADDR_W = NG_ADDR_W,
    parameter int DATA_W = NG_DATA_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    ngen_coef_if.slave  coef,
    ngen_wr_if.master   wr,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(P - 1);

    ld_state_t         state;
    logic [ADDR_W-1:0] k;
    logic [DATA_W-1:0] frz;
    logic              frz_bad;
    logic              xfer;

    rq_freeze #(
        .Q      (Q),
        .DATA_W (DATA_W)
    ) u_freeze (
        .x   (coef.in_coef),
        .y   (frz),
        .bad (frz_bad)
    );

    assign coef.in_ready = (state == LOAD);
    assign xfer          = coef.in_valid & coef.in_ready;

    // done is raised on leaving FINISH so it lands in the first IDLE cycle,
    // after the last write (issued during FINISH) has committed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            k            <= '0;
            wr.mem_we    <= 1'b0;
            wr.mem_waddr <= '0;
            wr.mem_wdata <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            wr.mem_we <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                        err   <= 1'b0;
                        k     <= '0;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        wr.mem_we    <= 1'b1;
                        wr.mem_waddr <= k;
                        wr.mem_wdata <= frz;
                        if (frz_bad)
                            err <= 1'b1;
                        if (k == K_LAST) begin
                            state <= FINISH;
                            k     <= '0;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ngen_loader.sv
// Bench for ngen_loader: table vectors, randomized loads against a simple model, reset/start corners.
module tb_ngen_loader;
    import ngen_loader_pkg::*;

    localparam int P    = NG_P;
    localparam int Q    = NG_Q;
    localparam int AW   = NG_ADDR_W;
    localparam int DW   = NG_DATA_W;
    localparam int HALF = (Q - 1) / 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, err;

    ngen_coef_if #(.DATA_W(DW))             cif ();
    ngen_wr_if   #(.ADDR_W(AW), .DATA_W(DW)) wif ();

    ngen_loader #(.P(P), .Q(Q), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .coef  (cif.slave),
        .wr    (wif.master),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int stim [P];
    int log_addr [$];
    int log_data [$];

    always @(negedge clk) begin
        if (wif.mem_we === 1'b1) begin
            log_addr.push_back(int'(wif.mem_waddr));
            log_data.push_back(int'(wif.mem_wdata));
        end
    end

    typedef struct {
        int pos;
        int coef;
        int exp_data;
        int exp_err;
    } vec_t;

    vec_t tbl [9];

    function automatic int freeze_ref(input int c);
        return (c < 0) ? c + Q : c;
    endfunction

    function automatic int model_err();
        int e = 0;
        for (int i = 0; i < P; i++)
            if (stim[i] > HALF || stim[i] < -HALF) e = 1;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_in_range();
        for (int i = 0; i < P; i++)
            stim[i] = int'($urandom_range(0, 2 * HALF)) - HALF;
    endtask

    task automatic do_start();
        log_addr.delete();
        log_data.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_ready", cif.in_ready, 1);
        check("start_err", err, 0);
    endtask

    // Streams stim[] until abort_at transfers; start is held high while idx==stray_at.
    task automatic load_body(input int pct, input int stray_at, input int abort_at);
        int  idx;
        int  cyc;
        bit  v;
        bit  rdy;
        idx = 0;
        cyc = 0;
        while (idx < abort_at && cyc < 40000) begin
            v            = ($urandom_range(99) < pct);
            cif.in_valid = v;
            cif.in_coef  = DW'(stim[idx]);
            start        = (idx == stray_at);
            rdy          = cif.in_ready;
            tick();
            cyc++;
            if (v && rdy) idx++;
        end
        cif.in_valid = 1'b0;
        start        = 1'b0;
        if (idx < abort_at) check("load_timeout", idx, abort_at);
    endtask

    task automatic finish_check(input int exp_err);
        check("fin_busy", busy, 1);
        check("fin_ready", cif.in_ready, 0);
        check("fin_done", done, 0);
        tick();
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_ready", cif.in_ready, 0);
        check("done_err", err, exp_err);
    endtask

    task automatic check_log();
        int n;
        check("n_writes", log_addr.size(), P);
        n = (log_addr.size() < P) ? log_addr.size() : P;
        for (int i = 0; i < n; i++) begin
            check("wr_addr", log_addr[i], i);
            check("wr_data", log_data[i], freeze_ref(stim[i]));
        end
    endtask

    task automatic full_load(input int pct, input int stray_at);
        do_start();
        load_body(pct, stray_at, P);
        finish_check(model_err());
        check_log();
    endtask

    initial begin
        tbl[0] = '{0,     -1,    4590, 0};
        tbl[1] = '{1,     -2295, 2296, 0};
        tbl[2] = '{5,     2296,  2296, 1};
        tbl[3] = '{7,     2295,  2295, 0};
        tbl[4] = '{8,     -2296, 2295, 1};
        tbl[5] = '{9,     4095,  4095, 1};
        tbl[6] = '{10,    -4096, 495,  1};
        tbl[7] = '{P - 1, -7,    4584, 0};
        tbl[8] = '{P - 1, 3000,  3000, 1};

        cif.in_valid = 1'b0;
        cif.in_coef  = '0;
        #3;
        check("rst_we", wif.mem_we, 0);
        check("rst_waddr", wif.mem_waddr, 0);
        check("rst_wdata", wif.mem_wdata, 0);
        check("rst_ready", cif.in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_busy", busy, 0);
        check("idle_ready", cif.in_ready, 0);

        // Identity stream: coefficient k at address k.
        for (int i = 0; i < P; i++) stim[i] = i;
        full_load(100, -1);
        tick();

        // Table vectors: one special coefficient per load; err must hold until the next start.
        for (int r = 0; r < 9; r++) begin
            fill_in_range();
            stim[tbl[r].pos] = tbl[r].coef;
            full_load(100, -1);
            if (log_data.size() > tbl[r].pos)
                check("tbl_data", log_data[tbl[r].pos], tbl[r].exp_data);
            else
                check("tbl_missing", log_data.size(), tbl[r].pos + 1);
            check("tbl_err", err, tbl[r].exp_err);
            tick();
            tick();
            check("err_hold", err, tbl[r].exp_err);
        end

        // Random stalls and coefficients; each start lands in the previous done cycle,
        // and a stray start is raised mid-load.
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < P; i++) begin
                if ($urandom_range(99) < 2)
                    stim[i] = int'($urandom_range(0, 8191)) - 4096;
                else
                    stim[i] = int'($urandom_range(0, 2 * HALF)) - HALF;
            end
            full_load(40 + 15 * it, 100 + 37 * it);
        end
        tick();

        // Reset in the middle of a load, with err already set.
        fill_in_range();
        stim[10] = 3000;
        do_start();
        load_body(100, -1, 300);
        check("pre_rst_err", err, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("pre_rst_writes", log_addr.size(), 299);
        check("mid_rst_we", wif.mem_we, 0);
        check("mid_rst_waddr", wif.mem_waddr, 0);
        check("mid_rst_wdata", wif.mem_wdata, 0);
        check("mid_rst_ready", cif.in_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err, 0);
        log_addr.delete();
        log_data.delete();
        cif.in_valid = 1'b1;
        repeat (4) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        cif.in_valid = 1'b0;
        check("post_rst_writes", log_addr.size(), 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_done", done, 0);
        fill_in_range();
        full_load(70, -1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
